// File: rtl/alu_seq_issue.sv
// Issue sequencer in front of an 8-bit combinational ALU; iterates shift/rotate
// opcodes through the ALU's single-bit shifter. Optional: ALU_SEQ_SHIFTOUT_EN.
module alu_seq_issue #(
  parameter int COUNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_opcode,
  input  logic [7:0]         req_a,
  input  logic [7:0]         req_b,
  input  logic [COUNT_W-1:0] req_count,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_opcode,
  input  logic [7:0]         alu_out,
  input  logic [7:0]         alu_flg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_data,
  output logic [7:0]         rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] load_cnt;
  logic [7:0]         final_flags;
  logic               accept;
  logic               last_pass;
  logic               rsp_done;

  assign accept    = (state == IDLE) && req_valid;
  assign last_pass = (state == EXEC) && (cnt == COUNT_W'(1));
  assign rsp_done  = rsp_valid && rsp_ready;

  // Held low while rst is asserted so nothing is offered during reset.
  assign req_ready = (state == IDLE) && !rst;

  // A zero shift count still performs one ALU pass.
  assign load_cnt = (req_opcode[2] && (req_count != '0)) ? req_count : COUNT_W'(1);

`ifdef ALU_SEQ_SHIFTOUT_EN
  // Bit leaving the operand on this pass: MSB for left moves, LSB for right moves.
  assign final_flags = alu_opcode[2] ? {alu_flg[7:1], (alu_opcode[0] ? alu_a[0] : alu_a[7])}
                                     : alu_flg;
`else
  assign final_flags = alu_flg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = EXEC;
      EXEC: if (last_pass) state_nxt = RESP;
      RESP: if (rsp_done)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so the ALU sees 0x00 operands out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
    end else if (accept) begin
      alu_a      <= req_a;
      alu_b      <= req_b;
      alu_opcode <= req_opcode;
      cnt        <= load_cnt;
    end else if (state == EXEC) begin
      cnt <= cnt - COUNT_W'(1);
      if (last_pass) begin
        rsp_data  <= alu_out;
        rsp_flags <= final_flags;
      end else begin
        alu_a <= alu_out;
      end
    end
  end

  // Response is offered one cycle after the final pass has been captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_valid <= 1'b0;
    else     rsp_valid <= (state == RESP) && !rsp_done;
  end

endmodule

// File: tb/tb_alu_seq_issue.sv
// Self-checking bench for alu_seq_issue: drives a behavioural ALU and compares
// responses against an iterate-N-times reference model.
module tb_alu_seq_issue;
  localparam int COUNT_W = 3;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_opcode;
  logic [7:0]         req_a;
  logic [7:0]         req_b;
  logic [COUNT_W-1:0] req_count;
  logic [7:0]         alu_a;
  logic [7:0]         alu_b;
  logic [3:0]         alu_opcode;
  logic [7:0]         alu_out;
  logic [7:0]         alu_flg;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [7:0]         rsp_data;
  logic [7:0]         rsp_flags;

  int checks = 0;
  int errors = 0;

  alu_seq_issue #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_count(req_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flg(alu_flg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: flags = {4'b0, zero, sign, overflow, carry}. Shifts leave carry clear.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0; v = 1'b0; r = 8'h00; s = 9'h000;
    if (!op[2]) begin
      case (op[1:0])
        2'b00: begin
          if (op[3]) begin
            s = {1'b0, a} - {1'b0, b};
            r = s[7:0];
            v = (a[7] != b[7]) && (r[7] != a[7]);
          end else begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            v = (a[7] == b[7]) && (r[7] != a[7]);
          end
          c = s[8];
        end
        2'b01:   r = a & b;
        2'b10:   r = a | b;
        default: r = a ^ b;
      endcase
    end else begin
      case (op[1:0])
        2'b00:   r = a << 1;
        2'b01:   r = a >> 1;
        2'b10:   r = {a[6:0], a[7]};
        default: r = {a[0], a[7:1]};
      endcase
    end
    return {4'b0000, (r == 8'h00), r[7], v, c, r};
  endfunction

  assign {alu_flg, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  function automatic int passes(input logic [3:0] op, input logic [COUNT_W-1:0] cnt);
    return (op[2] && cnt != 0) ? int'(cnt) : 1;
  endfunction

  // Reference: apply the ALU N times feeding the result back to A; {flags, data}.
  function automatic logic [15:0] ref_op(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [COUNT_W-1:0] cnt);
    logic [15:0] res;
    logic [7:0]  cur;
    logic [7:0]  prev;
    cur = a; prev = a; res = '0;
    for (int i = 0; i < passes(op, cnt); i++) begin
      prev = cur;
      res  = alu_fn(op, cur, b);
      cur  = res[7:0];
    end
`ifdef ALU_SEQ_SHIFTOUT_EN
    if (op[2]) res[8] = op[0] ? prev[0] : prev[7];
`endif
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [COUNT_W-1:0] cnt);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_count = cnt;
    tick();
    req_valid  = 1'b0;
    req_opcode = 4'($urandom);
    req_a      = 8'($urandom);
    req_b      = 8'($urandom);
    req_count  = COUNT_W'($urandom);
  endtask

  task automatic await_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_rsp(input int hold, input logic [15:0] exp);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(exp[7:0]));
      check("hold_flags", 32'(rsp_flags), 32'(exp[15:8]));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [COUNT_W-1:0] cnt, input int hold, input string tag);
    logic [15:0] exp;
    int          lat;
    exp = ref_op(op, a, b, cnt);
    send(op, a, b, cnt);
    await_rsp(0, lat);
    check({tag, "_lat"}, 32'(lat), 32'(passes(op, cnt) + 1));
    check({tag, "_data"}, 32'(rsp_data), 32'(exp[7:0]));
    check({tag, "_flags"}, 32'(rsp_flags), 32'(exp[15:8]));
    finish_rsp(hold, exp);
  endtask

  initial begin
    logic [15:0] exp;
    int          lat;
    int          seen;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = '0; req_a = '0; req_b = '0; req_count = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Directed cases with hand-derived expectations.
    send(4'b0000, 8'h7F, 8'h01, '0);
    await_rsp(0, lat);
    check("add_lat", 32'(lat), 32'd2);
    check("add_data", 32'(rsp_data), 32'h80);
    check("add_ovf_sign", 32'(rsp_flags[2:1]), 32'd3);
    finish_rsp(0, {rsp_flags, rsp_data});

    send(4'b0101, 8'h05, 8'h00, 3'd1);
    await_rsp(0, lat);
    check("shr_data", 32'(rsp_data), 32'h02);
`ifdef ALU_SEQ_SHIFTOUT_EN
    check("shr_shiftout", 32'(rsp_flags[0]), 32'd1);
`else
    check("shr_flags", 32'(rsp_flags), 32'h00);
`endif
    finish_rsp(0, {rsp_flags, rsp_data});

    send(4'b0100, 8'h81, 8'h00, 3'd3);
    check("shl_a0", 32'(alu_a), 32'h81);
    tick();
    check("shl_a1", 32'(alu_a), 32'h02);
    tick();
    check("shl_a2", 32'(alu_a), 32'h04);
    await_rsp(2, lat);
    check("shl_lat", 32'(lat), 32'd4);
    check("shl_data", 32'(rsp_data), 32'h08);
    finish_rsp(1, {rsp_flags, rsp_data});

    run_op(4'b0101, 8'h80, 8'h00, 3'd0, 0, "shr_cnt0");
    check("shr_cnt0_value", 32'(rsp_data), 32'h40);

    // Backpressure with a competing request held during RESP.
    send(4'b0000, 8'h12, 8'h34, '0);
    await_rsp(0, lat);
    check("bp_data", 32'(rsp_data), 32'h46);
    req_valid = 1'b1; req_opcode = 4'b1000; req_a = 8'h10; req_b = 8'h01; req_count = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data_hold", 32'(rsp_data), 32'h46);
      check("bp_flags_hold", 32'(rsp_flags), 32'h00);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_opcode_hold", 32'(alu_opcode), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    check("bp_req_ready_back", 32'(req_ready), 32'd1);
    check("bp_not_yet_taken", 32'(alu_opcode), 32'd0);
    tick();
    req_valid = 1'b0;
    check("bp_taken_op", 32'(alu_opcode), 32'h8);
    check("bp_taken_a", 32'(alu_a), 32'h10);
    await_rsp(0, lat);
    check("bp_sub_lat", 32'(lat), 32'd2);
    check("bp_sub_data", 32'(rsp_data), 32'h0F);
    finish_rsp(0, {rsp_flags, rsp_data});

    // Reset in the middle of a 7-pass rotate.
    send(4'b0110, 8'h01, 8'h00, 3'd7);
    tick();
    tick();
    check("rol_mid_a", 32'(alu_a), 32'h04);
    #2 rst = 1'b1;
    #1;
    check("arst_alu_a", 32'(alu_a), 32'd0);
    check("arst_alu_op", 32'(alu_opcode), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("arst_release_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("arst_no_rsp", 32'(seen), 32'd0);
    exp = ref_op(4'b1000, 8'h00, 8'h01, '0);
    check("sub_ref_sanity", 32'(exp[7:0]), 32'hFF);
    run_op(4'b1000, 8'h00, 8'h01, '0, 0, "sub_after_rst");
    check("sub_sign", 32'(rsp_flags[2]), 32'd1);

    // Randomized operations with random backpressure.
    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom), 8'($urandom), 8'($urandom), COUNT_W'($urandom),
             int'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
